// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: load/store width codes,
// FSM state encoding and the access legality rule.
// Latency: n/a (package). Backpressure: n/a.
package writeback_pkg;

  // funct3 width codes for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 width codes for stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Width code legal and address naturally aligned for that width.
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: access_ok = 1'b1;
      F3_LH, F3_LHU: access_ok = ~addr_lo[0];
      F3_LW:         access_ok = (addr_lo == 2'b00);
      default:       access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module writeback_load_align
  import writeback_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  // Shift the addressed byte to lane 0, then extend according to the width code.
  always_comb begin
    lane = rdata >> {byte_off, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data = {24'h0, lane[7:0]};
      F3_LHU:  data = {16'h0, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: register writeback, data-memory load/store over req/ack, retirement.
// Latency: 1 cycle for ALU ops; memory ops complete the cycle after dmem_ack (or after timeout).
// Backpressure: ex_ready is low for the whole time a memory access is outstanding.
module writeback
  import writeback_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_mem_addr,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_dest_reg_sel,
  input  logic [31:0] ex_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_dest_reg_sel,
  output logic [31:0] wb_data,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Context of the outstanding memory access, needed when the ack returns.
  logic             pend_load;
  logic [2:0]       pend_funct3;
  logic [1:0]       pend_off;
  logic [4:0]       pend_dest;
  logic [31:0]      pend_pc;

  logic             is_mem;
  logic             acc_ok;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      load_data;

  assign ex_ready = (state == IDLE);
  assign is_mem   = ex_mem_write | ex_mem_to_reg;
  assign acc_ok   = access_ok(ex_funct3, ex_mem_addr[1:0]);

  writeback_load_align u_load_align (
    .rdata    (dmem_rdata),
    .byte_off (pend_off),
    .funct3   (pend_funct3),
    .data     (load_data)
  );

  // Store byte enables and lane-replicated store data from the width code.
  always_comb begin
    st_strb = 4'b1111;
    st_data = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ex_mem_addr[1:0];
        st_data = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {ex_mem_addr[1], 1'b0};
        st_data = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Stage FSM: accept, issue memory access, wait for ack or timeout, emit single-cycle results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_wstrb      <= '0;
      wb_en           <= 1'b0;
      wb_dest_reg_sel <= '0;
      wb_data         <= '0;
      retire          <= 1'b0;
      retire_pc       <= '0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
      pend_load       <= 1'b0;
      pend_funct3     <= '0;
      pend_off        <= '0;
      pend_dest       <= '0;
      pend_pc         <= '0;
    end else begin
      wb_en           <= 1'b0;
      wb_dest_reg_sel <= '0;
      wb_data         <= '0;
      retire          <= 1'b0;
      retire_pc       <= '0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_en           <= (ex_dest_reg_sel != 5'd0);
              wb_dest_reg_sel <= ex_dest_reg_sel;
              wb_data         <= ex_result;
              retire          <= 1'b1;
              retire_pc       <= ex_pc;
            end else if (!acc_ok) begin
              misalign <= 1'b1;
            end else begin
              state       <= MEM_WAIT;
              wait_cnt    <= '0;
              dmem_req    <= 1'b1;
              dmem_we     <= ex_mem_write;
              dmem_addr   <= {ex_mem_addr[31:2], 2'b00};
              dmem_wdata  <= ex_mem_write ? st_data : 32'h0;
              dmem_wstrb  <= ex_mem_write ? st_strb : 4'b0000;
              pend_load   <= ~ex_mem_write;
              pend_funct3 <= ex_funct3;
              pend_off    <= ex_mem_addr[1:0];
              pend_dest   <= ex_dest_reg_sel;
              pend_pc     <= ex_pc;
            end
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // An ack in the timeout cycle still completes the access.
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            retire    <= 1'b1;
            retire_pc <= pend_pc;
            if (pend_load) begin
              wb_en           <= (pend_dest != 5'd0);
              wb_dest_reg_sel <= pend_dest;
              wb_data         <= load_data;
            end
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Randomized and directed checks of the writeback stage against a reference model.
// Latency: n/a (testbench).
// Backpressure: memory ack is driven by the bench at a chosen delay per access.
module tb_writeback;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_mem_addr;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_dest_reg_sel;
  logic [31:0] ex_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_en;
  logic [4:0]  wb_dest_reg_sel;
  logic [31:0] wb_data;
  logic        retire;
  logic [31:0] retire_pc;
  logic        misalign;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_result       (ex_result),
    .ex_store_data   (ex_store_data),
    .ex_mem_addr     (ex_mem_addr),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_funct3       (ex_funct3),
    .ex_dest_reg_sel (ex_dest_reg_sel),
    .ex_pc           (ex_pc),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
    .wb_en           (wb_en),
    .wb_dest_reg_sel (wb_dest_reg_sel),
    .wb_data         (wb_data),
    .retire          (retire),
    .retire_pc       (retire_pc),
    .misalign        (misalign),
    .bus_err         (bus_err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes implied by the width code.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  // Loaded value: take size bytes starting at the byte offset, optionally sign-extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint v;
    int     sz;
    sz = size_of(f3);
    v  = longint'(rd >> (8 * a[1:0])) % (longint'(1) << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic drive(input bit mw, input bit mr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] res, input logic [4:0] dest,
                       input logic [31:0] pc);
    ex_mem_write    = mw;
    ex_mem_to_reg   = mr;
    ex_funct3       = f3;
    ex_mem_addr     = addr;
    ex_store_data   = sd;
    ex_result       = res;
    ex_dest_reg_sel = dest;
    ex_pc           = pc;
  endtask

  // Issue one instruction, ack its memory access d cycles into the wait (if any),
  // and check every output cycle by cycle against the model's expected outcome.
  task automatic issue(input string name, input bit mw, input bit mr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] res,
                       input logic [4:0] dest, input logic [31:0] pc, input int d,
                       input logic [31:0] rd);
    bit          is_mem, is_ld, mis, berr, ret, wb;
    int          nreq, last, sz;
    logic [31:0] edata, ewd;
    logic [3:0]  estrb;
    is_mem = mw | mr;
    is_ld  = mr && !mw;
    mis    = is_mem && !legal(f3, addr);
    nreq = 0; berr = 0; ret = 0; wb = 0; edata = 0;
    if (!is_mem) begin
      ret = 1; wb = (dest != 0); edata = res;
    end else if (!mis) begin
      if (d <= TMO) begin
        nreq = d + 1; ret = 1; wb = is_ld && (dest != 0);
        edata = model_load(f3, addr, rd);
      end else begin
        nreq = TMO + 1; berr = 1;
      end
    end
    sz = size_of(f3);
    estrb = 4'b0000;
    ewd   = 32'h0;
    if (mw) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= int'(addr[1:0]) && i < int'(addr[1:0]) + sz) estrb[i] = 1'b1;
        ewd[8*i +: 8] = sd[8*(i % sz) +: 8];
      end
    end
    @(negedge clk);
    drive(mw, mr, f3, addr, sd, res, dest, pc);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    drive(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), $urandom);
    last = ((d > nreq) ? d : nreq) + 2;
    for (int c = 0; c <= last; c++) begin
      chk_eq({name, ":req"},      dmem_req, 32'(c < nreq));
      chk_eq({name, ":ready"},    ex_ready, 32'(c >= nreq));
      chk_eq({name, ":wb_en"},    wb_en,    32'(c == nreq && wb));
      chk_eq({name, ":retire"},   retire,   32'(c == nreq && ret));
      chk_eq({name, ":misalign"}, misalign, 32'(c == nreq && mis));
      chk_eq({name, ":bus_err"},  bus_err,  32'(c == nreq && berr));
      if (c < nreq) begin
        chk_eq({name, ":addr"},  dmem_addr,  addr & 32'hFFFF_FFFC);
        chk_eq({name, ":we"},    dmem_we,    32'(mw));
        chk_eq({name, ":wstrb"}, dmem_wstrb, 32'(estrb));
        chk_eq({name, ":wdata"}, dmem_wdata, ewd);
      end
      if (c == nreq && wb) begin
        chk_eq({name, ":wb_dest"}, wb_dest_reg_sel, 32'(dest));
        chk_eq({name, ":wb_data"}, wb_data, edata);
      end
      if (c == nreq && ret) chk_eq({name, ":retire_pc"}, retire_pc, pc);
      dmem_ack   = is_mem && (c == d);
      dmem_rdata = (c == d) ? rd : $urandom;
      @(negedge clk);
      dmem_ack = 1'b0;
    end
  endtask

  logic [2:0] ld_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_codes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    chk_eq("rst:ready",    ex_ready, 1);
    chk_eq("rst:req",      dmem_req, 0);
    chk_eq("rst:wb_en",    wb_en,    0);
    chk_eq("rst:wb_data",  wb_data,  0);
    chk_eq("rst:retire",   retire,   0);
    chk_eq("rst:misalign", misalign, 0);
    chk_eq("rst:bus_err",  bus_err,  0);
    chk_eq("rst:wstrb",    dmem_wstrb, 0);
    reset = 1'b0;

    // Back-to-back ALU ops, then one to x0.
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h11, 5'd5, 32'h100);
    ex_valid = 1'b1;
    @(negedge clk);
    chk_eq("b2b0:wb_en", wb_en, 1);
    chk_eq("b2b0:dest",  wb_dest_reg_sel, 5);
    chk_eq("b2b0:data",  wb_data, 32'h11);
    chk_eq("b2b0:ready", ex_ready, 1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h22, 5'd6, 32'h104);
    @(negedge clk);
    chk_eq("b2b1:wb_en",  wb_en, 1);
    chk_eq("b2b1:dest",   wb_dest_reg_sel, 6);
    chk_eq("b2b1:data",   wb_data, 32'h22);
    chk_eq("b2b1:retire", retire, 1);
    chk_eq("b2b1:ready",  ex_ready, 1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h33, 5'd0, 32'h108);
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("x0:wb_en",  wb_en, 0);
    chk_eq("x0:retire", retire, 1);
    chk_eq("x0:pc",     retire_pc, 32'h108);
    @(negedge clk);
    chk_eq("idle:retire", retire, 0);

    // Directed cases.
    issue("sb",     1, 0, 3'd0, 32'h1003, 32'h0000_00A5, 0, 5'd9,  32'h200, 2, 0);
    issue("lb",     0, 1, 3'd0, 32'h2001, 0, 0, 5'd10, 32'h204, 0, 32'h0000_8000);
    issue("lbu",    0, 1, 3'd4, 32'h2001, 0, 0, 5'd11, 32'h208, 1, 32'h0000_8000);
    issue("lhu",    0, 1, 3'd5, 32'h2002, 0, 0, 5'd12, 32'h20C, 0, 32'hBEEF_0000);
    issue("lw_mis", 0, 1, 3'd2, 32'h3002, 0, 0, 5'd13, 32'h210, 0, 0);
    issue("f3_011", 0, 1, 3'd3, 32'h3000, 0, 0, 5'd13, 32'h214, 0, 0);
    issue("tmo",    0, 1, 3'd2, 32'h4000, 0, 0, 5'd14, 32'h218, 8, 32'h1234_5678);
    issue("ack_at_tmo", 0, 1, 3'd2, 32'h4004, 0, 0, 5'd14, 32'h21C, TMO, 32'hCAFE_F00D);
    issue("after_tmo", 0, 0, 3'd0, 0, 0, 32'h77, 5'd15, 32'h220, 0, 0);

    // Reset while an access is outstanding.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd2, 32'h40, 0, 0, 5'd7, 32'h300);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("rmid:req_before", dmem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_eq("rmid:req",    dmem_req, 0);
    chk_eq("rmid:ready",  ex_ready, 1);
    chk_eq("rmid:wb_en",  wb_en, 0);
    chk_eq("rmid:retire", retire, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk_eq("late_ack:wb_en",  wb_en, 0);
    chk_eq("late_ack:retire", retire, 0);
    chk_eq("late_ack:req",    dmem_req, 0);
    chk_eq("late_ack:ready",  ex_ready, 1);

    // Randomized instruction mix.
    for (int k = 0; k < 300; k++) begin
      int          kind, d;
      logic [31:0] a;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d    = $urandom_range(0, 6);
      if (kind == 0) begin
        issue("rnd_alu", 0, 0, 3'($urandom), a, $urandom, $urandom, 5'($urandom), $urandom, 0, 0);
      end else if (kind == 1) begin
        f3 = ld_codes[$urandom_range(0, 7)];
        issue("rnd_ld", 0, 1, f3, a, $urandom, $urandom, 5'($urandom), $urandom, d, $urandom);
      end else begin
        f3 = st_codes[$urandom_range(0, 5)];
        issue("rnd_st", 1, 0, f3, a, $urandom, $urandom, 5'($urandom), $urandom, d, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
